// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM state encoding and frame constants for the UART blocks.
package uart_pkg;
  typedef enum logic [1:0] {IDLE = 2'b00, START = 2'b01, DATA = 2'b10, STOP = 2'b11} uart_state_t;
  localparam int UART_DATA_BITS = 8;
  localparam int UART_FRAME_BITS = 10;
  localparam int UART_CLKS_PER_BIT = 8;
endpackage

// File: rtl/uart_baud_cnt.sv
// uart_baud_cnt: bit-period cycle counter; tick marks the last cycle of each period.
module uart_baud_cnt #(
  parameter int CLKS_PER_BIT = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);
  localparam int W = $clog2(CLKS_PER_BIT);
  logic [W-1:0] cnt;
  assign tick = cnt == W'(CLKS_PER_BIT - 1);
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt <= '0;
    else cnt <= (clr || tick) ? '0 : cnt + W'(1);
endmodule

// File: rtl/uart_tx.sv
// uart_tx: 8N1 serial transmitter with registered tx and busy outputs.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] in,
  input  logic       load,
  output logic       tx,
  output logic       busy
);
  uart_state_t state, state_n;
  logic [7:0] shift, shift_n;
  logic [2:0] idx, idx_n;
  logic tick, tx_n, busy_n;
  uart_baud_cnt #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk(clk),
    .reset(reset),
    .clr(state == IDLE),
    .tick(tick)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      shift <= '0;
      idx   <= '0;
      tx    <= 1'b1;
      busy  <= 1'b0;
    end else begin
      state <= state_n;
      shift <= shift_n;
      idx   <= idx_n;
      tx    <= tx_n;
      busy  <= busy_n;
    end
  always_comb begin
    state_n = state;
    shift_n = shift;
    idx_n   = idx;
    case (state)
      IDLE: if (load) begin
        state_n = START;
        shift_n = in;
      end
      START: begin
        idx_n = '0;
        if (tick) state_n = DATA;
      end
      DATA: if (tick) begin
        shift_n = shift >> 1;
        idx_n   = idx + 3'd1;
        if (idx == 3'(UART_DATA_BITS - 1)) state_n = STOP;
      end
      STOP: if (tick) state_n = IDLE;
    endcase
  end
  // Outputs are precomputed from the next state so tx comes straight from a flop.
  always_comb begin
    tx_n   = state_n == START ? 1'b0 : state_n == DATA ? shift_n[0] : 1'b1;
    busy_n = state_n != IDLE;
  end
endmodule
